xmega_regs_ctx: RTL and testbench

XMEGA_REGS_CTX -- requirements
Module: xmega_regs_ctx

---
 rtl/xmega_regs_ctx_if.sv | 49 ++++
 rtl/xmega_regs_ctx.sv | 127 ++++++++++++
 tb/tb_xmega_regs_ctx.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xmega_regs_ctx_if.sv
// Bus bundle between the core, the context engine, the register file
// and the save/restore streams.
interface xmega_regs_ctx_if;
    // core side
    logic [4:0]  core_rs1a;
    logic [4:0]  core_rs2a;
    logic [4:0]  core_rda;
    logic        core_rs1m;
    logic        core_rs2m;
    logic        core_rdm;
    logic        core_rdw;
    logic [15:0] core_rd;
    // register-file side
    logic [4:0]  reg_rs1a;
    logic [4:0]  reg_rs2a;
    logic [4:0]  reg_rda;
    logic        reg_rs1m;
    logic        reg_rs2m;
    logic        reg_rdm;
    logic        reg_rdw;
    logic [15:0] reg_rd;
    logic [15:0] reg_rs1;
    // control and streams
    logic        save_req;
    logic        restore_req;
    logic [15:0] so_data;
    logic        so_valid;
    logic        so_ready;
    logic [15:0] si_data;
    logic        si_valid;
    logic        si_ready;
    logic        core_stall;
    logic        busy;
    logic        done;

    modport master (
        input  core_rs1a, core_rs2a, core_rda, core_rs1m, core_rs2m, core_rdm, core_rdw, core_rd,
        input  reg_rs1, save_req, restore_req, so_ready, si_data, si_valid,
        output reg_rs1a, reg_rs2a, reg_rda, reg_rs1m, reg_rs2m, reg_rdm, reg_rdw, reg_rd,
        output so_data, so_valid, si_ready, core_stall, busy, done
    );

    modport slave (
        output core_rs1a, core_rs2a, core_rda, core_rs1m, core_rs2m, core_rdm, core_rdw, core_rd,
        output reg_rs1, save_req, restore_req, so_ready, si_data, si_valid,
        input  reg_rs1a, reg_rs2a, reg_rda, reg_rs1m, reg_rs2m, reg_rdm, reg_rdw, reg_rd,
        input  so_data, so_valid, si_ready, core_stall, busy, done
    );
endinterface

// File: rtl/xmega_regs_ctx.sv
// Register-file context engine: streams the register pairs out (save) or
// in (restore) while holding the core; transparent to the core when idle.
module xmega_regs_ctx #(
    parameter string REGISTERED_OUTPUTS = "FALSE",
    parameter int    PAIRS              = 16
) (
    input logic              clk,
    input logic              rst,
    xmega_regs_ctx_if.master bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SAVE_FETCH = 3'd1;
    localparam logic [2:0] SAVE_SEND  = 3'd2;
    localparam logic [2:0] RESTORE    = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;

    localparam bit         READ_LAT1 = (REGISTERED_OUTPUTS == "TRUE");
    localparam logic [3:0] LAST_IDX  = 4'(PAIRS - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] so_data_q, so_data_d;
    logic        wait_q, wait_d;

    // Next state, pair index, captured save word and read-latency wait flag.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        so_data_d = so_data_q;
        wait_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.save_req) begin
                    state_d = SAVE_FETCH;
                    idx_d   = '0;
                end else if (bus.restore_req) begin
                    state_d = RESTORE;
                    idx_d   = '0;
                end
            end
            SAVE_FETCH: begin
                if (!READ_LAT1 || wait_q) begin
                    so_data_d = bus.reg_rs1;
                    state_d   = SAVE_SEND;
                end else begin
                    wait_d = 1'b1;
                end
            end
            SAVE_SEND: begin
                if (bus.so_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SAVE_FETCH;
                    end
                end
            end
            RESTORE: begin
                if (bus.si_valid) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            so_data_q <= '0;
            wait_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            so_data_q <= so_data_d;
            wait_q    <= wait_d;
        end
    end

    // Register-file port muxing, stream handshakes and status outputs.
    always_comb begin
        bus.reg_rs1a   = bus.core_rs1a;
        bus.reg_rs2a   = bus.core_rs2a;
        bus.reg_rda    = bus.core_rda;
        bus.reg_rs1m   = bus.core_rs1m;
        bus.reg_rs2m   = bus.core_rs2m;
        bus.reg_rdm    = bus.core_rdm;
        bus.reg_rdw    = bus.core_rdw;
        bus.reg_rd     = bus.core_rd;
        bus.so_data    = so_data_q;
        bus.so_valid   = 1'b0;
        bus.si_ready   = 1'b0;
        bus.core_stall = (state_q != IDLE);
        bus.busy       = (state_q != IDLE);
        bus.done       = (state_q == DONE);
        case (state_q)
            IDLE: ;
            SAVE_FETCH: begin
                bus.reg_rs1m = 1'b1;
                bus.reg_rs1a = {1'b0, idx_q};
                bus.reg_rdw  = 1'b0;
            end
            SAVE_SEND: begin
                bus.so_valid = 1'b1;
                bus.reg_rdw  = 1'b0;
            end
            RESTORE: begin
                bus.si_ready = 1'b1;
                bus.reg_rdm  = 1'b1;
                bus.reg_rda  = {1'b0, idx_q};
                bus.reg_rd   = bus.si_data;
                // Reset takes effect only at the next edge, so the write
                // strobe is masked here to stop a write in the abort cycle.
                bus.reg_rdw  = bus.si_valid & ~rst;
            end
            default: bus.reg_rdw = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_xmega_regs_ctx.sv
// Bench for xmega_regs_ctx: a 16-pair instance with combinational register
// file reads and a 4-pair instance with registered reads.
module tb_xmega_regs_ctx;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    xmega_regs_ctx_if bus0 ();
    xmega_regs_ctx_if bus1 ();

    xmega_regs_ctx #(.REGISTERED_OUTPUTS("FALSE"), .PAIRS(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    xmega_regs_ctx #(.REGISTERED_OUTPUTS("TRUE"),  .PAIRS(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Register files: 32 bytes; word mode addresses pair a[3:0].
    logic [7:0]  rf0 [32];
    logic [7:0]  rf1 [32];
    logic [15:0] rf1_rd_q;
    // Expected pair contents.
    logic [15:0] model0 [16];
    logic [15:0] model1 [4];

    always @(posedge clk) begin
        if (bus0.reg_rdw) begin
            if (bus0.reg_rdm) begin
                rf0[{bus0.reg_rda[3:0], 1'b0}] <= bus0.reg_rd[7:0];
                rf0[{bus0.reg_rda[3:0], 1'b1}] <= bus0.reg_rd[15:8];
            end else begin
                rf0[bus0.reg_rda] <= bus0.reg_rd[7:0];
            end
        end
    end
    assign bus0.reg_rs1 = bus0.reg_rs1m ? {rf0[{bus0.reg_rs1a[3:0], 1'b1}], rf0[{bus0.reg_rs1a[3:0], 1'b0}]}
                                        : {8'h00, rf0[bus0.reg_rs1a]};

    always @(posedge clk) begin
        if (bus1.reg_rdw) begin
            if (bus1.reg_rdm) begin
                rf1[{bus1.reg_rda[3:0], 1'b0}] <= bus1.reg_rd[7:0];
                rf1[{bus1.reg_rda[3:0], 1'b1}] <= bus1.reg_rd[15:8];
            end else begin
                rf1[bus1.reg_rda] <= bus1.reg_rd[7:0];
            end
        end
        rf1_rd_q <= bus1.reg_rs1m ? {rf1[{bus1.reg_rs1a[3:0], 1'b1}], rf1[{bus1.reg_rs1a[3:0], 1'b0}]}
                                  : {8'h00, rf1[bus1.reg_rs1a]};
    end
    assign bus1.reg_rs1 = rf1_rd_q;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.core_rs1a = '0; bus0.core_rs2a = '0; bus0.core_rda = '0;
        bus0.core_rs1m = 1'b0; bus0.core_rs2m = 1'b0; bus0.core_rdm = 1'b0; bus0.core_rdw = 1'b0;
        bus0.core_rd = '0; bus0.save_req = 1'b0; bus0.restore_req = 1'b0;
        bus0.so_ready = 1'b0; bus0.si_data = '0; bus0.si_valid = 1'b0;
        bus1.core_rs1a = '0; bus1.core_rs2a = '0; bus1.core_rda = '0;
        bus1.core_rs1m = 1'b0; bus1.core_rs2m = 1'b0; bus1.core_rdm = 1'b0; bus1.core_rdw = 1'b0;
        bus1.core_rd = '0; bus1.save_req = 1'b0; bus1.restore_req = 1'b0;
        bus1.so_ready = 1'b0; bus1.si_data = '0; bus1.si_valid = 1'b0;
    endtask

    task automatic write_pair0(input int k, input logic [15:0] v);
        bus0.core_rda = {1'b0, 4'(k)}; bus0.core_rdm = 1'b1; bus0.core_rdw = 1'b1; bus0.core_rd = v;
        next_cycle();
        bus0.core_rdw = 1'b0; bus0.core_rdm = 1'b0;
        model0[k] = v;
    endtask

    task automatic write_pair1(input int k, input logic [15:0] v);
        bus1.core_rda = {1'b0, 4'(k)}; bus1.core_rdm = 1'b1; bus1.core_rdw = 1'b1; bus1.core_rd = v;
        next_cycle();
        bus1.core_rdw = 1'b0; bus1.core_rdm = 1'b0;
        model1[k] = v;
    endtask

    task automatic check_pairs0(input string tag);
        for (int k = 0; k < 16; k++) begin
            bus0.core_rs1a = {1'b0, 4'(k)};
            bus0.core_rs1m = 1'b1;
            #1;
            n_checks++;
            if (bus0.reg_rs1 !== model0[k]) begin
                n_fail++;
                $display("FAIL %s_pair%0d: got %h expected %h", tag, k, bus0.reg_rs1, model0[k]);
            end
        end
        bus0.core_rs1m = 1'b0;
        bus0.core_rs1a = '0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        #4;
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
        n_checks++; if (bus0.core_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus0.core_stall); end
        n_checks++; if (bus0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus0.done); end
        n_checks++; if (bus0.so_valid !== 1'b0) begin n_fail++; $display("FAIL reset_so_valid: got %b expected 0", bus0.so_valid); end
        n_checks++; if (bus0.si_ready !== 1'b0) begin n_fail++; $display("FAIL reset_si_ready: got %b expected 0", bus0.si_ready); end
        n_checks++; if (bus0.so_data !== 16'h0000) begin n_fail++; $display("FAIL reset_so_data: got %h expected 0000", bus0.so_data); end
        n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b expected 0", bus1.busy); end
        n_checks++; if (bus1.so_data !== 16'h0000) begin n_fail++; $display("FAIL reset_so_data1: got %h expected 0000", bus1.so_data); end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 8; i++) begin
            bus0.core_rs1a = 5'($urandom); bus0.core_rs2a = 5'($urandom); bus0.core_rda = 5'($urandom);
            bus0.core_rs1m = 1'($urandom); bus0.core_rs2m = 1'($urandom); bus0.core_rdm = 1'($urandom);
            bus0.core_rdw = 1'($urandom); bus0.core_rd = 16'($urandom);
            bus1.core_rs1a = 5'($urandom); bus1.core_rs2a = 5'($urandom); bus1.core_rda = 5'($urandom);
            bus1.core_rs1m = 1'($urandom); bus1.core_rs2m = 1'($urandom); bus1.core_rdm = 1'($urandom);
            bus1.core_rdw = 1'($urandom); bus1.core_rd = 16'($urandom);
            #4;
            n_checks++;
            if ({bus0.reg_rs1a, bus0.reg_rs2a, bus0.reg_rda, bus0.reg_rs1m, bus0.reg_rs2m, bus0.reg_rdm, bus0.reg_rdw, bus0.reg_rd}
                !== {bus0.core_rs1a, bus0.core_rs2a, bus0.core_rda, bus0.core_rs1m, bus0.core_rs2m, bus0.core_rdm, bus0.core_rdw, bus0.core_rd}) begin
                n_fail++;
                $display("FAIL passthru0 i=%0d: got rs1a=%h rs2a=%h rda=%h rd=%h expected rs1a=%h rs2a=%h rda=%h rd=%h", i,
                         bus0.reg_rs1a, bus0.reg_rs2a, bus0.reg_rda, bus0.reg_rd, bus0.core_rs1a, bus0.core_rs2a, bus0.core_rda, bus0.core_rd);
            end
            n_checks++;
            if ({bus1.reg_rs1a, bus1.reg_rs2a, bus1.reg_rda, bus1.reg_rs1m, bus1.reg_rs2m, bus1.reg_rdm, bus1.reg_rdw, bus1.reg_rd}
                !== {bus1.core_rs1a, bus1.core_rs2a, bus1.core_rda, bus1.core_rs1m, bus1.core_rs2m, bus1.core_rdm, bus1.core_rdw, bus1.core_rd}) begin
                n_fail++;
                $display("FAIL passthru1 i=%0d: got rs1a=%h rda=%h rd=%h expected rs1a=%h rda=%h rd=%h", i,
                         bus1.reg_rs1a, bus1.reg_rda, bus1.reg_rd, bus1.core_rs1a, bus1.core_rda, bus1.core_rd);
            end
            n_checks++;
            if ({bus0.core_stall, bus0.so_valid, bus0.si_ready, bus0.busy} !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_status i=%0d: got %b expected 0000", i, {bus0.core_stall, bus0.so_valid, bus0.si_ready, bus0.busy});
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    // mode 0: so_ready held high; 1: five-cycle stall while on word 3; 2: random so_ready
    task automatic run_save0(input int mode, input bit both_req, input bit pulse_restore, input string tag);
        int c, got, stall_left;
        bit prev_wait, done_seen;
        c = 0; got = 0; stall_left = 5; prev_wait = 1'b0; done_seen = 1'b0;
        while (!done_seen && c < 400) begin
            bus0.save_req    = (c == 0);
            bus0.restore_req = ((c == 0) && both_req) || ((c == 10) && pulse_restore);
            if (c == 0) begin
                bus0.core_rdw = 1'b0;
            end else begin
                bus0.core_rda = 5'($urandom); bus0.core_rdm = 1'b1; bus0.core_rdw = 1'b1;
                bus0.core_rd = 16'($urandom); bus0.core_rs1a = 5'($urandom); bus0.core_rs1m = 1'($urandom);
            end
            if (mode == 0) begin
                bus0.so_ready = 1'b1;
            end else if (mode == 1) begin
                if (got == 3 && stall_left > 0) begin
                    bus0.so_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus0.so_ready = 1'b1;
                end
            end else begin
                bus0.so_ready = 1'($urandom_range(0, 1));
            end
            #4;
            n_checks++;
            if (bus0.core_stall !== (c > 0)) begin n_fail++; $display("FAIL %s_stall c=%0d: got %b expected %b", tag, c, bus0.core_stall, (c > 0)); end
            n_checks++;
            if (bus0.busy !== (c > 0)) begin n_fail++; $display("FAIL %s_busy c=%0d: got %b expected %b", tag, c, bus0.busy, (c > 0)); end
            if (c > 0) begin
                n_checks++;
                if (bus0.reg_rdw !== 1'b0) begin n_fail++; $display("FAIL %s_rdw c=%0d: got %b expected 0", tag, c, bus0.reg_rdw); end
            end
            if (prev_wait) begin
                n_checks++;
                if (bus0.so_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid_held c=%0d: got %b expected 1", tag, c, bus0.so_valid); end
            end
            if (bus0.so_valid === 1'b1) begin
                n_checks++;
                if (got >= 16) begin
                    n_fail++; $display("FAIL %s_extra_word c=%0d: got word %0d expected at most 16", tag, c, got + 1);
                end else if (bus0.so_data !== model0[got]) begin
                    n_fail++; $display("FAIL %s_word%0d c=%0d: got %h expected %h", tag, got, c, bus0.so_data, model0[got]);
                end
            end
            if (bus0.done === 1'b1) begin
                done_seen = 1'b1;
                n_checks++;
                if (got != 16) begin n_fail++; $display("FAIL %s_count: got %0d expected 16", tag, got); end
                if (mode == 0) begin
                    n_checks++;
                    if (c != 33) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected 33", tag, c); end
                end
            end
            if (bus0.so_valid === 1'b1 && bus0.so_ready) got++;
            prev_wait = (bus0.so_valid === 1'b1) && !bus0.so_ready;
            next_cycle();
            c++;
        end
        idle_inputs();
        n_checks++;
        if (!done_seen) begin n_fail++; $display("FAIL %s_timeout: got no done in %0d cycles expected done", tag, c); end
        n_checks++;
        if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after: got %b expected 0", tag, bus0.busy); end
    endtask

    // mode 0: si_valid low every other cycle, data A000+k; 1: random valid/data; 2: valid held high, random data
    task automatic run_restore0(input int mode, input int abort_at, input string tag);
        logic [15:0] vals [16];
        logic [15:0] wv;
        int c, sent, wk;
        bit aborting, finished;
        for (int k = 0; k < 16; k++) vals[k] = (mode == 0) ? 16'hA000 + 16'(k) : 16'($urandom);
        wk = $urandom_range(0, 15);
        wv = 16'($urandom);
        c = 0; sent = 0; finished = 1'b0;
        while (!finished && c < 200) begin
            aborting = (c > 0) && (abort_at >= 0) && (sent == abort_at);
            bus0.restore_req = (c == 0);
            if (c == 0) begin
                bus0.core_rda = {1'b0, 4'(wk)}; bus0.core_rdm = 1'b1; bus0.core_rdw = 1'b1; bus0.core_rd = wv;
                bus0.si_valid = 1'b0;
            end else begin
                bus0.core_rda = 5'($urandom); bus0.core_rdm = 1'b1; bus0.core_rdw = 1'b1; bus0.core_rd = 16'($urandom);
                if (mode == 0)      bus0.si_valid = c[0];
                else if (mode == 1) bus0.si_valid = 1'($urandom_range(0, 1));
                else                bus0.si_valid = 1'b1;
            end
            bus0.si_data = (sent < 16) ? vals[sent] : 16'($urandom);
            rst = aborting;
            #4;
            if (c == 0) begin
                n_checks++;
                if (bus0.reg_rdw !== 1'b1) begin n_fail++; $display("FAIL %s_req_cycle_write: got %b expected 1", tag, bus0.reg_rdw); end
                n_checks++;
                if (bus0.si_ready !== 1'b0) begin n_fail++; $display("FAIL %s_req_cycle_ready: got %b expected 0", tag, bus0.si_ready); end
                model0[wk] = wv;
            end else if (sent == 16) begin
                finished = 1'b1;
                n_checks++;
                if ({bus0.done, bus0.si_ready, bus0.reg_rdw} !== 3'b100) begin
                    n_fail++; $display("FAIL %s_done_cycle c=%0d: got done/ready/rdw %b expected 100", tag, c, {bus0.done, bus0.si_ready, bus0.reg_rdw});
                end
                if (mode == 2) begin
                    n_checks++;
                    if (c != 17) begin n_fail++; $display("FAIL %s_rate: got done at %0d expected 17", tag, c); end
                end
            end else begin
                n_checks++;
                if ({bus0.done, bus0.si_ready} !== 2'b01) begin
                    n_fail++; $display("FAIL %s_status c=%0d: got done/ready %b expected 01", tag, c, {bus0.done, bus0.si_ready});
                end
                n_checks++;
                if (bus0.reg_rdw !== (bus0.si_valid && !aborting)) begin
                    n_fail++; $display("FAIL %s_rdw c=%0d: got %b expected %b", tag, c, bus0.reg_rdw, (bus0.si_valid && !aborting));
                end
                n_checks++;
                if ({bus0.reg_rdm, bus0.reg_rda, bus0.reg_rd} !== {1'b1, 1'b0, 4'(sent), bus0.si_data}) begin
                    n_fail++; $display("FAIL %s_wport c=%0d: got rdm=%b rda=%h rd=%h expected rdm=1 rda=%h rd=%h", tag, c,
                                       bus0.reg_rdm, bus0.reg_rda, bus0.reg_rd, sent, bus0.si_data);
                end
                if (aborting) begin
                    finished = 1'b1;
                end else if (bus0.si_valid) begin
                    model0[sent] = vals[sent];
                    sent++;
                end
            end
            next_cycle();
            c++;
        end
        rst = 1'b0;
        idle_inputs();
        n_checks++;
        if (!finished) begin n_fail++; $display("FAIL %s_timeout: got no completion in %0d cycles expected completion", tag, c); end
        n_checks++;
        if ({bus0.busy, bus0.core_stall} !== 2'b00) begin
            n_fail++; $display("FAIL %s_idle_after: got busy/stall %b expected 00", tag, {bus0.busy, bus0.core_stall});
        end
        next_cycle();
    endtask

    task automatic test_save_preload();
        for (int k = 0; k < 16; k++) write_pair0(k, 16'h1100 + 16'(k));
        run_save0(0, 1'b0, 1'b0, "save_basic");
        check_pairs0("save_basic_keep");
    endtask

    task automatic test_save_backpressure();
        run_save0(1, 1'b0, 1'b0, "save_stall");
    endtask

    task automatic test_restore_alternating();
        run_restore0(0, -1, "restore_alt");
        check_pairs0("restore_alt");
    endtask

    task automatic test_concurrent_req();
        run_save0(0, 1'b1, 1'b1, "both_req");
        check_pairs0("both_req_keep");
    endtask

    task automatic test_restore_full_rate();
        run_restore0(2, -1, "restore_full");
        check_pairs0("restore_full");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) write_pair0(k, 16'($urandom));
            run_save0(2, 1'b0, 1'b0, "rand_save");
            run_restore0(1, -1, "rand_restore");
            check_pairs0("rand_pairs");
        end
    endtask

    task automatic test_restore_abort();
        for (int k = 0; k < 16; k++) write_pair0(k, 16'($urandom));
        run_restore0(0, 7, "abort");
        check_pairs0("abort_pairs");
    endtask

    task automatic test_registered_save();
        int c, got;
        bit done_seen;
        for (int k = 0; k < 4; k++) write_pair1(k, 16'($urandom));
        c = 0; got = 0; done_seen = 1'b0;
        while (!done_seen && c < 100) begin
            bus1.save_req = (c == 0);
            bus1.so_ready = 1'b1;
            #4;
            if (bus1.so_valid === 1'b1) begin
                n_checks++;
                if (got >= 4) begin
                    n_fail++; $display("FAIL reg_save_extra c=%0d: got word %0d expected at most 4", c, got + 1);
                end else if (bus1.so_data !== model1[got]) begin
                    n_fail++; $display("FAIL reg_save_word%0d: got %h expected %h", got, bus1.so_data, model1[got]);
                end
                n_checks++;
                if (c != 3 + 3 * got) begin n_fail++; $display("FAIL reg_save_timing%0d: got cycle %0d expected %0d", got, c, 3 + 3 * got); end
                got++;
            end
            if (bus1.done === 1'b1) begin
                done_seen = 1'b1;
                n_checks++;
                if (got != 4 || c != 13) begin n_fail++; $display("FAIL reg_save_done: got words=%0d cycle=%0d expected 4 and 13", got, c); end
            end
            next_cycle();
            c++;
        end
        idle_inputs();
        n_checks++;
        if (!done_seen) begin n_fail++; $display("FAIL reg_save_timeout: got no done in %0d cycles expected done", c); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_passthrough();
        test_save_preload();
        test_save_backpressure();
        test_restore_alternating();
        test_concurrent_req();
        test_restore_full_rate();
        test_random();
        test_restore_abort();
        test_registered_save();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
